// File: rtl/bcm_scanner.sv
// bcm_scanner: binary-coded-modulation scan engine driving a 32x32 LED matrix from two pixel RAMs
module bcm_scanner #(
  parameter int CDEPTH        = 4,
  parameter int MCLK_DIV_BITS = 2,
  parameter int LATCH_CYCLES  = 2,
  parameter int BASE_TICKS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fstart,
  output logic                fend,
  output logic [8:0]          rd_addr,
  input  logic [3*CDEPTH-1:0] lo_pix,
  input  logic [3*CDEPTH-1:0] hi_pix,
  output logic [2:0]          lo_rgb,
  output logic [2:0]          hi_rgb,
  output logic [3:0]          row,
  output logic                mclk,
  output logic                latch,
  output logic                oe
);
  localparam int PW = CDEPTH > 1 ? $clog2(CDEPTH) : 1;
  localparam int CW = $clog2((BASE_TICKS << (CDEPTH - 1)) + LATCH_CYCLES + 1);
  localparam int IW = $clog2(3 * CDEPTH);
  localparam logic [PW-1:0] LAST_PLANE = PW'(CDEPTH - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] BT = CW'(BASE_TICKS);
  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, SHOW, DONE} state_t;
  state_t r_state, w_next;
  logic [MCLK_DIV_BITS-1:0] r_div;
  logic [4:0] r_col;
  logic [3:0] r_row, r_row_out;
  logic [PW-1:0] r_plane;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] w_b0, w_b1, w_b2;
  logic w_col_end, w_shift_end, w_latch_end, w_show_end, w_last_plane;
  assign w_col_end    = r_div == '1;
  assign w_shift_end  = r_state == SHIFT && w_col_end && r_col == 5'd31;
  assign w_latch_end  = r_state == LATCH && r_cnt == LATCH_LAST;
  assign w_show_end   = r_state == SHOW && r_cnt == (BT << r_plane) - CW'(1);
  assign w_last_plane = r_plane == LAST_PLANE;
  assign w_b0 = IW'(r_plane);
  assign w_b1 = w_b0 + IW'(CDEPTH);
  assign w_b2 = w_b1 + IW'(CDEPTH);
  assign rd_addr = {r_row, r_col};
  assign row     = r_row_out;
  assign mclk    = r_state == SHIFT && r_div[MCLK_DIV_BITS-1];
  assign latch   = r_state == LATCH;
  assign oe      = r_state != SHOW;
  assign fend    = r_state == DONE;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = fstart ? SHIFT : IDLE;
      SHIFT:   w_next = w_shift_end ? LATCH : SHIFT;
      LATCH:   w_next = w_latch_end ? SHOW : LATCH;
      SHOW:    w_next = !w_show_end ? SHOW : (w_last_plane && r_row == 4'd15) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_row_out <= '0;
      r_plane   <= '0;
      r_cnt     <= '0;
      lo_rgb    <= '0;
      hi_rgb    <= '0;
    end else begin
      r_div <= r_state == SHIFT ? r_div + MCLK_DIV_BITS'(1) : '0;
      r_cnt <= ((r_state == LATCH && !w_latch_end) || (r_state == SHOW && !w_show_end)) ? r_cnt + CW'(1) : '0;
      if (r_state == SHIFT && w_col_end) r_col <= r_col + 5'd1;
      if (w_shift_end) r_row_out <= r_row;
      if (r_state == SHIFT && r_div == MCLK_DIV_BITS'(1)) begin
        lo_rgb <= {lo_pix[w_b2], lo_pix[w_b1], lo_pix[w_b0]};
        hi_rgb <= {hi_pix[w_b2], hi_pix[w_b1], hi_pix[w_b0]};
      end
      if (r_state == IDLE && fstart) begin
        r_row   <= '0;
        r_plane <= '0;
        r_col   <= '0;
      end else if (w_show_end) begin
        r_plane <= w_last_plane ? '0 : r_plane + PW'(1);
        r_row   <= w_last_plane ? r_row + 4'd1 : r_row;
      end
    end
  end
endmodule

// File: tb/tb_bcm_scanner.sv
// tb_bcm_scanner: directed self-checking bench for bcm_scanner with registered-read RAM model
module tb_bcm_scanner;
  logic clk = 0, reset = 1, fstart = 1;
  logic fend, mclk, latch, oe;
  logic [8:0] rd_addr;
  logic [11:0] lo_pix, hi_pix;
  logic [2:0] lo_rgb, hi_rgb;
  logic [3:0] row;
  logic [11:0] lo_mem [512];
  logic [11:0] hi_mem [512];
  int n_chk = 0, n_fail = 0, cyc = 0;
  typedef struct packed {
    int r;
    int c;
    logic [11:0] lo;
    logic [11:0] hi;
    logic [11:0] elo;
    logic [11:0] ehi;
  } vec_t;
  vec_t vecs [8];
  logic p_mclk = 0, p_latch = 0, p_oe = 1, lat_bad = 0;
  logic [3:0] lat_row = 0;
  int rises = 0, n_oe = 0, n_lat = 0, n_fend = 0, oe_len = 0, lat_len = 0;
  logic [2:0] cap_lo [4096];
  logic [2:0] cap_hi [4096];
  int oe_run [4096];
  int lat_len_a [4096];
  int lat_row_a [4096];
  int lat_bad_a [4096];
  int lat_rise_a [4096];
  int fend_cyc [16];

  bcm_scanner dut (
    .clk(clk), .reset(reset), .fstart(fstart), .fend(fend), .rd_addr(rd_addr),
    .lo_pix(lo_pix), .hi_pix(hi_pix), .lo_rgb(lo_rgb), .hi_rgb(hi_rgb),
    .row(row), .mclk(mclk), .latch(latch), .oe(oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    lo_pix <= lo_mem[rd_addr];
    hi_pix <= hi_mem[rd_addr];
  end

  always @(negedge clk) begin
    if (mclk === 1'b1 && p_mclk !== 1'b1) begin
      cap_lo[rises % 4096] = lo_rgb;
      cap_hi[rises % 4096] = hi_rgb;
      rises++;
    end
    if (oe === 1'b0) oe_len++;
    else if (p_oe === 1'b0) begin
      oe_run[n_oe % 4096] = oe_len;
      n_oe++;
      oe_len = 0;
    end
    if (latch === 1'b1) begin
      if (p_latch !== 1'b1) begin
        lat_len = 0;
        lat_row = row;
        lat_bad = 0;
        lat_rise_a[n_lat % 4096] = rises;
      end
      lat_len++;
      if (row !== lat_row) lat_bad = 1;
    end else if (p_latch === 1'b1) begin
      lat_len_a[n_lat % 4096] = lat_len;
      lat_row_a[n_lat % 4096] = int'(lat_row);
      lat_bad_a[n_lat % 4096] = int'(lat_bad);
      n_lat++;
    end
    if (fend === 1'b1) begin
      fend_cyc[n_fend % 16] = cyc;
      n_fend++;
    end
    p_mclk = mclk;
    p_latch = latch;
    p_oe = oe;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 100000 && cyc < target; i++) tick();
  endtask

  task automatic start_frame(output int t);
    fstart = 1;
    t = cyc;
    tick();
    fstart = 0;
  endtask

  task automatic wait_fend(input int nf0, output int fc);
    for (int i = 0; i < 20000 && n_fend == nf0; i++) tick();
    chk("fend_seen", n_fend > nf0, 1);
    fc = n_fend > nf0 ? fend_cyc[nf0 % 16] : -1;
  endtask

  task automatic check_frame(input string tag, input int rb, input int lb, input int ob);
    int b_pass, b_len, b_stab, b_row, b_oe;
    b_pass = 0; b_len = 0; b_stab = 0; b_row = 0; b_oe = 0;
    chk({tag, "_mclk_rises"}, rises - rb, 2048);
    chk({tag, "_latch_pulses"}, n_lat - lb, 64);
    chk({tag, "_oe_runs"}, n_oe - ob, 64);
    for (int i = 0; i < 64; i++) begin
      int j, prev;
      j = (lb + i) % 4096;
      prev = i == 0 ? rb : lat_rise_a[(lb + i - 1) % 4096];
      if (lat_rise_a[j] - prev != 32) b_pass++;
      if (lat_len_a[j] != 2) b_len++;
      if (lat_bad_a[j] != 0) b_stab++;
      if (lat_row_a[j] != i / 4) b_row++;
      if (oe_run[(ob + i) % 4096] != (8 << (i % 4))) b_oe++;
    end
    chk({tag, "_pass_rises_bad"}, b_pass, 0);
    chk({tag, "_latch_len_bad"}, b_len, 0);
    chk({tag, "_latch_row_unstable"}, b_stab, 0);
    chk({tag, "_latch_row_seq_bad"}, b_row, 0);
    chk({tag, "_oe_run_bad"}, b_oe, 0);
    chk({tag, "_oe_run_first"}, oe_run[ob % 4096], 8);
    chk({tag, "_oe_run_p3"}, oe_run[(ob + 3) % 4096], 64);
  endtask

  initial begin
    int t, fc, fc2, nf, rb, lb, ob, bad;
    vecs[0] = '{3,  5,  12'h5A3, 12'h000, {3'b010, 3'b100, 3'b011, 3'b101}, 12'h000};
    vecs[1] = '{3,  6,  12'h000, 12'h000, 12'h000, 12'h000};
    vecs[2] = '{0,  0,  12'hFFF, 12'h000, {3'b111, 3'b111, 3'b111, 3'b111}, 12'h000};
    vecs[3] = '{15, 31, 12'h000, 12'h0F0, 12'h000, {3'b010, 3'b010, 3'b010, 3'b010}};
    vecs[4] = '{7,  16, 12'h800, 12'h00C, {3'b100, 3'b000, 3'b000, 3'b000}, {3'b001, 3'b001, 3'b000, 3'b000}};
    vecs[5] = '{10, 1,  12'h124, 12'h421, {3'b000, 3'b001, 3'b010, 3'b100}, {3'b000, 3'b100, 3'b010, 3'b001}};
    vecs[6] = '{12, 30, 12'h000, 12'h5A3, 12'h000, {3'b010, 3'b100, 3'b011, 3'b101}};
    vecs[7] = '{15, 0,  12'h00F, 12'hF00, {3'b001, 3'b001, 3'b001, 3'b001}, {3'b100, 3'b100, 3'b100, 3'b100}};
    foreach (lo_mem[i]) begin
      lo_mem[i] = 12'hFFF;
      hi_mem[i] = 12'hFFF;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_oe", oe, 1);
      chk("rst_latch", latch, 0);
      chk("rst_mclk", mclk, 0);
      chk("rst_fend", fend, 0);
      chk("rst_row", row, 0);
    end
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_lo_rgb", lo_rgb, 0);
    chk("rst_hi_rgb", hi_rgb, 0);
    reset = 0;
    fstart = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (oe !== 1'b1 || mclk !== 1'b0 || latch !== 1'b0) bad++;
    end
    chk("idle_after_reset_bad", bad, 0);
    rb = rises; lb = n_lat; ob = n_oe; nf = n_fend;
    start_frame(t);
    wait_fend(nf, fc);
    chk("allff_frame_len", fc - t, 10241);
    bad = 0;
    for (int k = 0; k < 2048; k++)
      if (cap_lo[(rb + k) % 4096] !== 3'b111 || cap_hi[(rb + k) % 4096] !== 3'b111) bad++;
    chk("allff_rgb_bad", bad, 0);
    check_frame("allff", rb, lb, ob);
    tick();
    tick();
    chk("fend_one_cycle", n_fend - nf, 1);
    foreach (lo_mem[i]) begin
      lo_mem[i] = 0;
      hi_mem[i] = 0;
    end
    foreach (vecs[i]) begin
      lo_mem[vecs[i].r * 32 + vecs[i].c] = vecs[i].lo;
      hi_mem[vecs[i].r * 32 + vecs[i].c] = vecs[i].hi;
    end
    rb = rises; lb = n_lat; ob = n_oe; nf = n_fend;
    start_frame(t);
    wait_fend(nf, fc);
    chk("vec_frame_len", fc - t, 10241);
    foreach (vecs[i])
      for (int p = 0; p < 4; p++) begin
        int k;
        k = (rb + vecs[i].r * 128 + p * 32 + vecs[i].c) % 4096;
        chk($sformatf("vec%0d_lo_p%0d", i, p), cap_lo[k], vecs[i].elo[3*p +: 3]);
        chk($sformatf("vec%0d_hi_p%0d", i, p), cap_hi[k], vecs[i].ehi[3*p +: 3]);
      end
    check_frame("vec", rb, lb, ob);
    tick();
    nf = n_fend;
    start_frame(t);
    wait_until(t + 50);
    chk("t5_in_shift_oe", oe, 1);
    fstart = 1;
    tick();
    fstart = 0;
    for (int i = 0; i < 2000 && oe !== 1'b0; i++) tick();
    chk("t5_show_reached", oe, 0);
    fstart = 1;
    tick();
    fstart = 0;
    wait_until(t + 10000);
    fstart = 1;
    wait_fend(nf, fc);
    chk("t5_frame_len", fc - t, 10241);
    tick();
    tick();
    fstart = 0;
    wait_fend(nf + 1, fc2);
    chk("t5_restart_gap", fc2 - fc, 10242);
    tick();
    tick();
    nf = n_fend;
    start_frame(t);
    wait_until(t + 4905);
    chk("t6_pre_oe", oe, 0);
    chk("t6_pre_row", row, 7);
    chk("t6_pre_latch", latch, 0);
    reset = 1;
    tick();
    chk("t6_rst_oe", oe, 1);
    chk("t6_rst_row", row, 0);
    chk("t6_rst_mclk", mclk, 0);
    chk("t6_rst_latch", latch, 0);
    reset = 0;
    wait_until(cyc + 6000);
    chk("t6_no_fend", n_fend - nf, 0);
    chk("t6_idle_oe", oe, 1);
    start_frame(t);
    wait_fend(nf, fc);
    chk("t6_frame_len", fc - t, 10241);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
